// File: rtl/reg_writeback.sv
// reg_writeback: writeback stage feeding the single register-file write port.
// Merges single-cycle ALU results with in-order load responses, which are
// byte/halfword extracted and sign/zero extended. Outstanding loads are kept
// in a LOAD_DEPTH-entry FIFO of {rd, funct3, addr_lo}.
// Latency: a result accepted in cycle N appears on o_reg_w_* in cycle N+1.
// Backpressure: load responses are never stalled and always win, so
// o_alu_ready = !i_mem_rvalid. o_ld_ready = (count < LOAD_DEPTH).
// Ports: i_CLK/i_RST (sync, active-high); ALU in (i_alu_*, o_alu_ready);
// load issue (i_ld_*, o_ld_ready); memory response (i_mem_rvalid, i_mem_rdata);
// write port (o_reg_w_sel, o_reg_w_data); hazard mask (o_pend_mask);
// empty-FIFO response error pulse (o_ld_err).
// Build option: define PEND_MASK_EN to generate o_pend_mask. Without it the
// mask is tied to zero and the per-entry decode is dropped.
module reg_writeback #(
  parameter int LOAD_DEPTH = 2
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  output logic        o_alu_ready,
  input  logic        i_ld_issue,
  input  logic [4:0]  i_ld_rd,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  output logic        o_ld_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [4:0]  o_reg_w_sel,
  output logic [31:0] o_reg_w_data,
  output logic [31:0] o_pend_mask,
  output logic        o_ld_err
);

  localparam int PW = $clog2(LOAD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LOAD_DEPTH);

  // FIFO storage; entry validity is derived from the pointers and count.
  logic [4:0]    rd_q [LOAD_DEPTH];
  logic [2:0]    f3_q [LOAD_DEPTH];
  logic [1:0]    lo_q [LOAD_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    sel_q, sel_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;

  logic          push, pop;
  logic [4:0]    head_rd;
  logic [2:0]    head_f3;
  logic [1:0]    head_lo;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_data;

  assign o_ld_ready  = (cnt_q < DEPTH_C);
  assign o_alu_ready = !i_mem_rvalid;

  assign pop  = i_mem_rvalid && (cnt_q != '0);
  // A pop frees a slot in the same edge, so an issue coinciding with a
  // response is taken even while full and the count stays at LOAD_DEPTH.
  assign push = i_ld_issue && (o_ld_ready || pop);

  assign head_rd = rd_q[rd_ptr_q];
  assign head_f3 = f3_q[rd_ptr_q];
  assign head_lo = lo_q[rd_ptr_q];

  // Extraction of the popped load; addr_lo[0] is ignored for halfwords.
  always_comb begin
    byte_v  = i_mem_rdata[{head_lo, 3'b000} +: 8];
    half_v  = i_mem_rdata[{head_lo[1], 4'b0000} +: 16];
    case (head_f3)
      3'b000:  ld_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  ld_data = {{16{half_v[15]}}, half_v};
      3'b100:  ld_data = {24'd0, byte_v};
      3'b101:  ld_data = {16'd0, half_v};
      default: ld_data = i_mem_rdata;
    endcase
  end

  // Write-port arbitration: load response, else ALU, else idle.
  always_comb begin
    sel_d  = 5'd0;
    data_d = data_q;
    err_d  = 1'b0;
    if (pop) begin
      sel_d  = head_rd;
      data_d = ld_data;
    end else if (i_mem_rvalid) begin
      err_d  = 1'b1;
    end else if (i_alu_valid) begin
      sel_d  = i_alu_rd;
      data_d = i_alu_data;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  // Entry payload needs no reset: it is only observed while counted valid.
  always_ff @(posedge i_CLK) begin
    if (push) begin
      rd_q[wr_ptr_q] <= i_ld_rd;
      f3_q[wr_ptr_q] <= i_ld_funct3;
      lo_q[wr_ptr_q] <= i_ld_addr_lo;
    end
  end

  assign o_reg_w_sel  = sel_q;
  assign o_reg_w_data = data_q;
  assign o_ld_err     = err_q;

`ifdef PEND_MASK_EN
  logic [31:0] mask_v;
  logic [PW-1:0] off_v;

  // Entry i is live when its distance from the read pointer is below count.
  always_comb begin
    mask_v = 32'd0;
    off_v  = '0;
    for (int i = 0; i < LOAD_DEPTH; i++) begin
      off_v = PW'(i) - rd_ptr_q;
      if ({1'b0, off_v} < cnt_q) begin
        mask_v[rd_q[i]] = 1'b1;
      end
    end
    mask_v[0] = 1'b0;
  end

  assign o_pend_mask = mask_v;
`else
  assign o_pend_mask = 32'd0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed stimulus for reg_writeback with LOAD_DEPTH=2.
// A queue-based model predicts every output each cycle; a negedge process
// compares it against the DUT, and the driver pins key literal values.
module tb_reg_writeback;

  localparam int D = 2;

  logic        i_CLK = 1'b0;
  logic        i_RST;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        o_alu_ready;
  logic        i_ld_issue;
  logic [4:0]  i_ld_rd;
  logic [2:0]  i_ld_funct3;
  logic [1:0]  i_ld_addr_lo;
  logic        o_ld_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic [4:0]  o_reg_w_sel;
  logic [31:0] o_reg_w_data;
  logic [31:0] o_pend_mask;
  logic        o_ld_err;

  reg_writeback #(.LOAD_DEPTH(D)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .o_alu_ready(o_alu_ready),
    .i_ld_issue(i_ld_issue), .i_ld_rd(i_ld_rd), .i_ld_funct3(i_ld_funct3),
    .i_ld_addr_lo(i_ld_addr_lo), .o_ld_ready(o_ld_ready),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_reg_w_sel(o_reg_w_sel), .o_reg_w_data(o_reg_w_data),
    .o_pend_mask(o_pend_mask), .o_ld_err(o_ld_err)
  );

  always #5 i_CLK = ~i_CLK;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [4:0] rd; logic [2:0] f3; logic [1:0] lo; } ent_t;
  ent_t        q[$];
  logic [4:0]  exp_sel  = 5'd0;
  logic [31:0] exp_data = 32'd0;
  logic        exp_err  = 1'b0;

  function automatic logic [31:0] extract(input ent_t e, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * e.lo)) & 32'hFF;
    h = (w >> (16 * (e.lo / 2))) & 32'hFFFF;
    case (e.f3)
      3'd0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = 32'd0;
`ifdef PEND_MASK_EN
    foreach (q[i]) m = m | (32'd1 << q[i].rd);
    m[0] = 1'b0;
`endif
    return m;
  endfunction

  always @(posedge i_CLK) begin
    if (i_RST) begin
      q.delete();
      exp_sel = 5'd0; exp_data = 32'd0; exp_err = 1'b0;
    end else begin
      bit popped;
      popped  = i_mem_rvalid && (q.size() > 0);
      exp_err = i_mem_rvalid && !popped;
      exp_sel = 5'd0;
      if (popped) begin
        ent_t e;
        e = q.pop_front();
        exp_sel  = e.rd;
        exp_data = extract(e, i_mem_rdata);
      end else if (!i_mem_rvalid && i_alu_valid) begin
        exp_sel  = i_alu_rd;
        exp_data = i_alu_data;
      end
      if (i_ld_issue && (q.size() < D)) begin
        ent_t n;
        n.rd = i_ld_rd; n.f3 = i_ld_funct3; n.lo = i_ld_addr_lo;
        q.push_back(n);
      end
    end
  end

  always @(negedge i_CLK) begin
    if (chk_en) begin
      check("sel",       {27'd0, o_reg_w_sel}, {27'd0, exp_sel});
      check("data",      o_reg_w_data, exp_data);
      check("ld_err",    {31'd0, o_ld_err}, {31'd0, exp_err});
      check("alu_ready", {31'd0, o_alu_ready}, {31'd0, !i_mem_rvalid});
      check("ld_ready",  {31'd0, o_ld_ready}, {31'd0, q.size() < D});
      check("pend_mask", o_pend_mask, model_mask());
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge i_CLK);
    #2;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    i_ld_issue = 1'b1; i_ld_rd = rd; i_ld_funct3 = f3; i_ld_addr_lo = lo;
  endtask

  function automatic logic [31:0] pm(input logic [31:0] v);
`ifdef PEND_MASK_EN
    return v;
`else
    return v & 32'd0;
`endif
  endfunction

  initial begin
    i_RST = 1'b1;
    i_alu_valid = 1'b0; i_alu_rd = '0; i_alu_data = '0;
    i_ld_issue = 1'b0; i_ld_rd = '0; i_ld_funct3 = '0; i_ld_addr_lo = '0;
    i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_sel",      {27'd0, o_reg_w_sel}, 32'd0);
    check("rst_data",     o_reg_w_data, 32'd0);
    check("rst_err",      {31'd0, o_ld_err}, 32'd0);
    check("rst_ld_ready", {31'd0, o_ld_ready}, 32'd1);
    check("rst_mask",     o_pend_mask, 32'd0);
    i_RST = 1'b0;

    // ALU write, then idle
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'h1234_5678;
    tick();
    i_alu_valid = 1'b0;
    check("alu_sel",  {27'd0, o_reg_w_sel}, 32'd5);
    check("alu_data", o_reg_w_data, 32'h1234_5678);
    tick();
    check("alu_sel_clr", {27'd0, o_reg_w_sel}, 32'd0);
    check("alu_hold",    o_reg_w_data, 32'h1234_5678);

    // rd=0 never produces a write select
    i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'h99;
    tick();
    i_alu_valid = 1'b0;
    check("rd0_sel", {27'd0, o_reg_w_sel}, 32'd0);

    // LB rd7 addr_lo=3
    issue(5'd7, 3'b000, 2'd3);
    tick();
    i_ld_issue = 1'b0;
    check("lb_mask", o_pend_mask, pm(32'h0000_0080));
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h80AA_BBCC;
    tick();
    i_mem_rvalid = 1'b0;
    check("lb_sel",  {27'd0, o_reg_w_sel}, 32'd7);
    check("lb_data", o_reg_w_data, 32'hFFFF_FF80);
    check("lb_mask_clr", o_pend_mask, 32'd0);

    // LHU rd6 addr_lo=2 on same word
    issue(5'd6, 3'b101, 2'd2);
    tick();
    i_ld_issue = 1'b0;
    i_mem_rvalid = 1'b1;
    tick();
    i_mem_rvalid = 1'b0;
    check("lhu_sel",  {27'd0, o_reg_w_sel}, 32'd6);
    check("lhu_data", o_reg_w_data, 32'h0000_80AA);

    // ALU rd3 collides with load response rd4
    issue(5'd4, 3'b010, 2'd0);
    tick();
    i_ld_issue = 1'b0;
    i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'h0000_0033;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
    #1 check("coll_alu_ready", {31'd0, o_alu_ready}, 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    check("coll_ld_sel",  {27'd0, o_reg_w_sel}, 32'd4);
    check("coll_ld_data", o_reg_w_data, 32'hDEAD_BEEF);
    #1 check("coll_alu_ready2", {31'd0, o_alu_ready}, 32'd1);
    tick();
    i_alu_valid = 1'b0;
    check("coll_alu_sel",  {27'd0, o_reg_w_sel}, 32'd3);
    check("coll_alu_data", o_reg_w_data, 32'h0000_0033);

    // Fill to depth, then push+pop while full
    issue(5'd8, 3'b010, 2'd0);
    tick();
    issue(5'd9, 3'b010, 2'd0);
    tick();
    i_ld_issue = 1'b0;
    #1 check("full_ld_ready", {31'd0, o_ld_ready}, 32'd0);
    check("full_mask", o_pend_mask, pm(32'h0000_0300));
    issue(5'd10, 3'b010, 2'd0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1111_1111;
    tick();
    i_ld_issue = 1'b0;
    i_mem_rvalid = 1'b0;
    check("full_pp_sel", {27'd0, o_reg_w_sel}, 32'd8);
    check("full_pp_ready", {31'd0, o_ld_ready}, 32'd0);
    check("full_pp_mask", o_pend_mask, pm(32'h0000_0600));
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h2222_2222;
    tick();
    check("drain9", {27'd0, o_reg_w_sel}, 32'd9);
    tick();
    i_mem_rvalid = 1'b0;
    check("drain10", {27'd0, o_reg_w_sel}, 32'd10);
    check("drain_ready", {31'd0, o_ld_ready}, 32'd1);

    // Response with empty FIFO
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5;
    tick();
    i_mem_rvalid = 1'b0;
    check("empty_err", {31'd0, o_ld_err}, 32'd1);
    check("empty_sel", {27'd0, o_reg_w_sel}, 32'd0);
    tick();
    check("empty_err_clr", {31'd0, o_ld_err}, 32'd0);

    // Reset with two loads outstanding
    issue(5'd12, 3'b010, 2'd0);
    tick();
    issue(5'd13, 3'b010, 2'd0);
    tick();
    i_ld_issue = 1'b0;
    i_RST = 1'b1;
    tick();
    i_RST = 1'b0;
    check("mrst_ready", {31'd0, o_ld_ready}, 32'd1);
    check("mrst_mask",  o_pend_mask, 32'd0);
    check("mrst_sel",   {27'd0, o_reg_w_sel}, 32'd0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hAAAA_5555;
    tick();
    check("mrst_err1", {31'd0, o_ld_err}, 32'd1);
    check("mrst_sel1", {27'd0, o_reg_w_sel}, 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    check("mrst_err2", {31'd0, o_ld_err}, 32'd1);
    tick();
    check("mrst_err_clr", {31'd0, o_ld_err}, 32'd0);

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
